imem_loader: RTL and testbench
==============================

# imem_loader

Byte-stream program loader that writes the instruction memory's write port and holds the core while a program is being loaded. It receives bytes on a valid/ready stream (normally from the UART receiver), parses a framed image (sync, length, payload, checksum), and packs the payload little-endian into 32-bit words. It commits each word to the instruction memory at consecutive word addresses from 0. The core is released only after a complete, checksum-valid image has been written.

## Interface
- ADDR_WIDTH, 3, instruction memory word-address width; depth = 2**ADDR_WIDTH words (8).
- SYNC_BYTE, 8'hA5, frame start marker.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_data  input  8  stream byte.
- in_valid  input  1  in_data valid.
- in_ready  output  1  loader can accept a byte; a byte transfers when in_valid && in_ready.
- imem_we  output  1  instruction memory write enable, one-cycle pulse.
- imem_waddr  output  ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  word to write.
- core_hold  output  1  1 holds the core (fetch and PC) in reset.
- load_done  output  1  image loaded and verified.
- load_error  output  1  frame rejected.

## Operation
- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE: the loader discards every byte except SYNC_BYTE. SYNC_BYTE moves to LEN_LO and clears the word counter, byte counter and checksum.
- LEN_LO / LEN_HI: capture a 16-bit word count, low byte first. After LEN_HI, a count of 0 or greater than 2**ADDR_WIDTH goes to ERR; any other count goes to DATA.
- DATA:
  - Each accepted byte is placed at lane byte_cnt (lane 0 = bits 7:0) and XORed into the 8-bit checksum.
  - On the 4th byte, the loader registers the write: imem_waddr = word_cnt, imem_wdata = assembled word. Then byte_cnt returns to 0 and word_cnt increments.
  - After the last word, the state moves to CSUM.
- CSUM: the next byte is compared with the XOR of all payload bytes. Equal goes to DONE; unequal goes to ERR.
- DONE: load_done = 1, core_hold = 0. SYNC_BYTE restarts a load (LEN_LO, core_hold = 1, load_done = 0). Other bytes are discarded.
- ERR: load_error = 1, core_hold = 1. SYNC_BYTE restarts as from DONE and clears load_error. Other bytes are discarded.
- A SYNC_BYTE value received inside LEN_LO/LEN_HI/DATA/CSUM is ordinary data; there is no resynchronisation mid-frame.
- Words already written are never cleared. An aborted or failed load leaves partial contents in memory, and the core stays held.

## Timing
- Reset values: state IDLE, in_ready 1, imem_we 0, imem_waddr 0, imem_wdata 0, core_hold 1, load_done 0, load_error 0, all counters 0.
- All outputs are registered.
- imem_we rises the cycle after the 4th byte of a word is accepted and stays high for exactly one cycle. imem_waddr and imem_wdata are stable in that cycle.
- in_ready is 0 in the cycle imem_we = 1 and 1 in every other cycle. A byte presented then is not consumed; the source must hold it.
- Maximum throughput is 4 bytes per 5 cycles in DATA, and 1 byte per cycle elsewhere.
- load_done or load_error rises the cycle after the checksum byte is accepted. For a bad length, load_error rises the cycle after the LEN_HI byte is accepted.
- core_hold falls in the same cycle load_done rises. core_hold rises the cycle after a restarting SYNC_BYTE is accepted.
- rst asserted in any state, including mid-write: the next edge applies reset values. A write pulse pending in that cycle is dropped.
- in_valid low between bytes (any gap length) has no effect on state or counters.

## Test plan
- Single word: A5, 01, 00, 13, 00, 50, 00, 43 -> one imem_we pulse with addr 0, wdata 32'h00500013; then load_done = 1, core_hold = 0, load_error = 0.
- Full image: A5, 08, 00, then 32 bytes where word k = 32'h0000_0k13, then the correct XOR -> 8 pulses at addr 0..7 with matching data; in_ready is low on exactly those 8 cycles; load_done = 1.
- Bad checksum: the single-word frame with final byte 44 -> the write at addr 0 still occurs; load_error = 1, core_hold = 1. A following valid frame -> load_error clears and load_done = 1.
- Length out of range: A5, 09, 00 -> load_error = 1 the cycle after the 00 byte, no imem_we. A5, 00, 00 -> same.
- Noise and backpressure: bytes 00, FF, 5A before A5 are ignored. Random in_valid gaps during a 2-word load give identical writes. A byte held across an in_ready = 0 cycle is consumed exactly once.
- Reset mid-load: rst pulsed after the 2nd payload byte of word 1 -> IDLE, core_hold = 1, no further writes, word 0 stays in memory. A new complete frame then loads correctly.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream program loader for the instruction memory.
//
// Frame format: SYNC_BYTE, word count (16 bit, low byte first), payload
// (count * 4 bytes, packed little-endian into 32-bit words), XOR checksum
// of the payload bytes. Words are written to consecutive addresses from 0.
// The core is held until a complete, checksum-valid image has been written.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   in_data     stream byte
//   in_valid    in_data valid
//   in_ready    loader can accept a byte (transfer on in_valid && in_ready)
//   imem_we     instruction memory write enable, one-cycle pulse
//   imem_waddr  word address of the write
//   imem_wdata  word to write
//   core_hold   1 holds the core in reset
//   load_done   image loaded and verified
//   load_error  frame rejected
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [31:0]           imem_wdata,
    output logic                  core_hold,
    output logic                  load_done,
    output logic                  load_error
);

    localparam logic [15:0]         MAX_LEN = 16'(2 ** ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    state_t              state, state_n;
    logic                accept;
    logic                wr_n;
    logic                is_sync;
    logic [7:0]          len_lo;
    logic [15:0]         len_full;
    logic [ADDR_WIDTH:0] len_words;
    logic [ADDR_WIDTH:0] word_cnt;
    logic [1:0]          byte_cnt;
    logic [7:0]          csum;
    logic [23:0]         word_buf;   // lanes 0..2; lane 3 comes straight from in_data

    assign accept   = in_valid && in_ready;
    assign is_sync  = (in_data == SYNC_BYTE);
    assign len_full = {in_data, len_lo};

    // Next-state and write-request logic.
    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_n = state;
        wr_n    = 1'b0;
        case (state)
            IDLE, DONE, ERR: begin
                if (accept && is_sync) state_n = LEN_LO;
            end
            LEN_LO: begin
                if (accept) state_n = LEN_HI;
            end
            LEN_HI: begin
                if (accept) begin
                    if (len_full == 16'd0 || len_full > MAX_LEN) state_n = ERR;
                    else                                           state_n = DATA;
                end
            end
            DATA: begin
                if (accept && byte_cnt == 2'd3) begin
                    wr_n = 1'b1;
                    if (word_cnt + CNT_ONE == len_words) state_n = CSUM;
                end
            end
            CSUM: begin
                if (accept) state_n = (in_data == csum) ? DONE : ERR;
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered control outputs. Status flags follow the next
    // state so they change in the same cycle the state does.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            imem_we    <= 1'b0;
            core_hold  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
        end else begin
            state      <= state_n;
            imem_we    <= wr_n;
            // The byte slot in the write cycle is skipped; the source holds it.
            in_ready   <= !wr_n;
            core_hold  <= (state_n != DONE);
            load_done  <= (state_n == DONE);
            load_error <= (state_n == ERR);
        end
    end

    // Datapath: length capture, byte packing, counters and checksum.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_lo     <= '0;
            len_words  <= '0;
            word_cnt   <= '0;
            byte_cnt   <= '0;
            csum       <= '0;
            word_buf   <= '0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else if (accept) begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (is_sync) begin
                        word_cnt <= '0;
                        byte_cnt <= '0;
                        csum     <= '0;
                    end
                end
                LEN_LO: len_lo <= in_data;
                // Only the low bits matter once the range check has passed.
                LEN_HI: len_words <= len_full[ADDR_WIDTH:0];
                DATA: begin
                    csum     <= csum ^ in_data;
                    byte_cnt <= byte_cnt + 2'd1;   // wraps to 0 after lane 3
                    case (byte_cnt)
                        2'd0: word_buf[7:0]   <= in_data;
                        2'd1: word_buf[15:8]  <= in_data;
                        2'd2: word_buf[23:16] <= in_data;
                        default: begin
                            imem_waddr <= word_cnt[ADDR_WIDTH-1:0];
                            imem_wdata <= {in_data, word_buf};
                            word_cnt   <= word_cnt + CNT_ONE;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: a table of framed images with
// hand-computed expected writes and status, plus hand-written sequences for
// gaps, restart, reset mid-load and reset dropping a pending write.
module tb_imem_loader;

    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic          core_hold;
    logic          load_done;
    logic          load_error;

    imem_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .core_hold  (core_hold),
        .load_done  (load_done),
        .load_error (load_error)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Write monitor, sampled on the falling edge.
    logic [31:0] wr_addr [128];
    logic [31:0] wr_data [128];
    int          wr_count   = 0;
    int          ready_low  = 0;
    int          ready_bad  = 0;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr[wr_count & 127] = 32'(imem_waddr);
            wr_data[wr_count & 127] = imem_wdata;
            wr_count++;
        end
        if (!in_ready) ready_low++;
        if (in_ready == imem_we) ready_bad++;
    end

    // Stimulus table.
    typedef struct {
        string        name;
        int           start;
        int           n;
        int           exp_nw;
        logic [255:0] exp_w;
        bit           exp_done;
        bit           exp_err;
    } vec_t;

    logic [7:0] pool [$];
    vec_t       vecs [$];
    int         gap_max = 0;

    task automatic add_vec(input string name, input int start, input int nw,
                           input logic [255:0] w, input bit d, input bit e);
        vec_t v;
        v.name = name; v.start = start; v.n = pool.size() - start;
        v.exp_nw = nw; v.exp_w = w; v.exp_done = d; v.exp_err = e;
        vecs.push_back(v);
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        bit rdy;
        if (gap_max > 0) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        forever begin
            rdy = in_ready;
            @(posedge clk);
            if (rdy) break;
            @(negedge clk);
            waited++;
            if (waited > 20) begin
                n_total++;
                $display("FAIL handshake: in_ready low for %0d cycles, expected at most 1", waited);
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   base_w, base_r;
        v = vecs[idx];
        base_w = wr_count;
        base_r = ready_low;
        for (int j = 0; j < v.n; j++) send_byte(pool[v.start + j]);
        in_valid = 1'b0;
        // Status changes the cycle after the final byte is accepted.
        check({v.name, " load_done"},  32'(load_done),  32'(v.exp_done));
        check({v.name, " load_error"}, 32'(load_error), 32'(v.exp_err));
        check({v.name, " core_hold"},  32'(core_hold),  32'(!v.exp_done));
        repeat (2) @(negedge clk);
        check({v.name, " write count"},      32'(wr_count - base_w),  32'(v.exp_nw));
        check({v.name, " in_ready low cyc"}, 32'(ready_low - base_r), 32'(v.exp_nw));
        for (int i = 0; i < v.exp_nw; i++) begin
            check($sformatf("%s addr[%0d]", v.name, i), wr_addr[(base_w + i) & 127], 32'(i));
            check($sformatf("%s data[%0d]", v.name, i), wr_data[(base_w + i) & 127], v.exp_w[i*32 +: 32]);
        end
    endtask

    initial begin
        int           s;
        int           base_w;
        int           idx_two;
        logic [255:0] w;

        // ---- table ----
        s = pool.size();
        pool = {pool, 8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h43};
        add_vec("single", s, 1, 256'h00500013, 1'b1, 1'b0);

        s = pool.size();
        pool = {pool, 8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h44};
        add_vec("bad_csum", s, 1, 256'h00500013, 1'b0, 1'b1);

        s = pool.size();
        pool = {pool, 8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h43};
        add_vec("recover", s, 1, 256'h00500013, 1'b1, 1'b0);

        s = pool.size();
        pool = {pool, 8'hA5, 8'h09, 8'h00};
        add_vec("len9", s, 0, 256'h0, 1'b0, 1'b1);

        s = pool.size();
        pool = {pool, 8'hA5, 8'h00, 8'h00};
        add_vec("len0", s, 0, 256'h0, 1'b0, 1'b1);

        s = pool.size();
        pool = {pool, 8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00,
                8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
        add_vec("noise", s, 1, 256'h12345678, 1'b1, 1'b0);

        s = pool.size();
        pool = {pool, 8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
        add_vec("sync_as_data", s, 1, 256'hA5A5A5A5, 1'b1, 1'b0);

        s = pool.size();
        w = '0;
        pool = {pool, 8'hA5, 8'h08, 8'h00};
        for (int k = 0; k < 8; k++) begin
            pool = {pool, 8'h13, 8'(k), 8'h00, 8'h00};
            w[k*32 +: 32] = 32'h0000_0013 | (32'(k) << 8);
        end
        pool = {pool, 8'h00};   // 13 eight times and 0..7 both XOR to zero
        add_vec("full", s, 8, w, 1'b1, 1'b0);

        s = pool.size();
        pool = {pool, 8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h04};
        idx_two = vecs.size();
        add_vec("two_word", s, 2, {192'h0, 32'hDDCCBBAA, 32'h04030201}, 1'b1, 1'b0);

        // ---- reset values ----
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst in_ready",   32'(in_ready),   32'd1);
        check("rst imem_we",    32'(imem_we),    32'd0);
        check("rst imem_waddr", 32'(imem_waddr), 32'd0);
        check("rst imem_wdata", imem_wdata,      32'd0);
        check("rst core_hold",  32'(core_hold),  32'd1);
        check("rst load_done",  32'(load_done),  32'd0);
        check("rst load_error", 32'(load_error), 32'd0);

        // ---- table-driven frames ----
        for (int i = 0; i < vecs.size(); i++) run_vec(i);

        // ---- restart from DONE raises core_hold the next cycle ----
        send_byte(8'hA5);
        in_valid = 1'b0;
        check("restart core_hold", 32'(core_hold), 32'd1);
        check("restart load_done", 32'(load_done), 32'd0);
        // finish it as a two-word frame (SYNC already sent)
        for (int j = 1; j < vecs[idx_two].n; j++) send_byte(pool[vecs[idx_two].start + j]);
        in_valid = 1'b0;
        check("restart finish done", 32'(load_done), 32'd1);

        // ---- random in_valid gaps give identical writes ----
        gap_max = 3;
        run_vec(idx_two);
        gap_max = 0;

        // ---- reset mid-load after 2nd byte of word 1 ----
        base_w = wr_count;
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        send_byte(8'hAA); send_byte(8'hBB);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst core_hold",  32'(core_hold),  32'd1);
        check("midrst load_done",  32'(load_done),  32'd0);
        check("midrst load_error", 32'(load_error), 32'd0);
        check("midrst in_ready",   32'(in_ready),   32'd1);
        send_byte(8'hCC); send_byte(8'hDD); send_byte(8'h04);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst write count", 32'(wr_count - base_w), 32'd1);
        check("midrst word0 data",  wr_data[base_w & 127],  32'h04030201);
        check("midrst still held",  32'(core_hold),         32'd1);
        run_vec(0);

        // ---- reset on the edge that accepts a 4th byte drops the write ----
        base_w = wr_count;
        send_byte(8'hA5); send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        in_data  = 8'h44;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("droprst imem_we", 32'(imem_we), 32'd0);
        repeat (3) @(negedge clk);
        check("droprst write count", 32'(wr_count - base_w), 32'd0);
        check("droprst core_hold",   32'(core_hold),         32'd1);

        check("in_ready vs imem_we", 32'(ready_bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
